// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: EX/MEM and MEM/WB payloads,
// memory-op encodings, MEM FSM states and misaligned-access trap codes.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [2:0] {
    MEM_IDLE = 3'd0,
    MEM_REQ  = 3'd1,
    MEM_WAIT = 3'd2,
    MEM_DONE = 3'd3,
    MEM_DROP = 3'd4
  } mem_state_t;

  localparam logic [5:0] TRAP_CODE_LOAD_ADDR_MISALIGNED  = {1'b0, 5'd4};
  localparam logic [5:0] TRAP_CODE_STORE_ADDR_MISALIGNED = {1'b0, 5'd6};

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_csr_result;
    logic [31:0] store_data;
    mem_op_t     mem_op;
    logic [4:0]  rd_addr;
    logic        trap_valid;
    logic [5:0]  trap_mcause;
    logic [31:0] trap_pc;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        trap_valid;
    logic [5:0]  trap_mcause;
    logic [31:0] trap_pc;
  } mem_wb_t;

  function automatic logic mem_op_is_load(mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic mem_op_is_store(mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// One rvalid is returned for every granted request, loads and stores alike.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane formatting for the data bus: store strobes/replicated data,
// load lane extraction with sign/zero extension, misalignment detection.
module mem_lsu_align
  import mem_stage_pkg::*;
(
  input  mem_op_t     mem_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // pick the addressed byte and half-word lanes out of the read word
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // per-op strobes, write data, load extension and alignment check
  always_comb begin
    wstrb_o      = 4'b0000;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    case (mem_op_i)
      MEM_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_data_o = {24'd0, byte_sel};
      MEM_LH: begin
        load_data_o  = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      MEM_LHU: begin
        load_data_o  = {16'd0, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      MEM_LW: misaligned_o = (addr_lo_i != 2'b00);
      MEM_SB: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_SH: begin
        wstrb_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      MEM_SW: begin
        wstrb_o      = 4'b1111;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-bus FSM, load result buffer,
// misaligned-access traps and the MEM/WB next-state payload.
//
// state | meaning
// IDLE  | no transaction outstanding; requests combinationally when needed
// REQ   | request presented but not yet granted; bus fields held
// WAIT  | granted, waiting for rvalid
// DONE  | response captured in rbuf while EX/MEM is stalled
// DROP  | instruction flushed after grant; swallow the stray response
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  ex_mem_t            ex_pipeline_d_i,
  input  logic               ex_mem_stall_i,
  input  logic               ex_mem_flush_i,
  input  logic               mem_wb_stall_i,
  input  logic               mem_wb_flush_i,
  mem_stage_if.master        dmem,
  output logic               mem_busy_o,
  output logic [31:0]        mem_alu_csr_result_o,
  output logic [4:0]         mem_rd_addr_o,
  output logic               mem_trap_valid_o,
  output mem_wb_t            mem_pipeline_d_o
);

  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_state_t  state_q, state_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic [3:0]  lsu_wstrb;
  logic [31:0] lsu_wdata, lsu_load_data, lsu_rdata;
  logic        misaligned, is_load, is_store, acc, advance, mis_trap;
  logic        req, busy;

  assign is_load  = mem_op_is_load(ex_mem_q.mem_op);
  assign is_store = mem_op_is_store(ex_mem_q.mem_op);

  // once parked in DONE the bus may move on, so extract from the buffer
  assign lsu_rdata = (state_q == MEM_DONE) ? rbuf_q : dmem.dmem_rdata;

  mem_lsu_align u_align (
    .mem_op_i     (ex_mem_q.mem_op),
    .addr_lo_i    (ex_mem_q.alu_csr_result[1:0]),
    .store_data_i (ex_mem_q.store_data),
    .rdata_i      (lsu_rdata),
    .wstrb_o      (lsu_wstrb),
    .wdata_o      (lsu_wdata),
    .load_data_o  (lsu_load_data),
    .misaligned_o (misaligned)
  );

  assign acc = ex_mem_q.valid & ~ex_mem_q.trap_valid &
               (ex_mem_q.mem_op != MEM_NONE) & ~misaligned;
  assign advance  = ex_mem_flush_i | ~ex_mem_stall_i;
  assign mis_trap = ex_mem_q.valid & ~ex_mem_q.trap_valid & misaligned;

  // EX/MEM register next value: flush beats stall, stall holds
  always_comb begin
    ex_mem_d = ex_pipeline_d_i;
    if (ex_mem_flush_i) begin
      ex_mem_d            = ex_mem_q;
      ex_mem_d.valid      = 1'b0;
      ex_mem_d.trap_valid = 1'b0;
    end else if (ex_mem_stall_i) begin
      ex_mem_d = ex_mem_q;
    end
  end

  // bus FSM next state, request and busy
  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    req     = 1'b0;
    busy    = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        req  = acc;
        busy = acc;
        if (acc) begin
          // a grant coinciding with a flush still owes us a response
          if (dmem.dmem_gnt)       state_d = ex_mem_flush_i ? MEM_DROP : MEM_WAIT;
          else if (!ex_mem_flush_i) state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        req  = ~ex_mem_flush_i;
        busy = 1'b1;
        if (ex_mem_flush_i)     state_d = MEM_IDLE;
        else if (dmem.dmem_gnt) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        busy = ~dmem.dmem_rvalid;
        if (dmem.dmem_rvalid) begin
          if (advance) begin
            state_d = MEM_IDLE;
          end else begin
            rbuf_d  = dmem.dmem_rdata;
            state_d = MEM_DONE;
          end
        end else if (ex_mem_flush_i) begin
          state_d = MEM_DROP;
        end
      end
      MEM_DONE: begin
        if (advance) state_d = MEM_IDLE;
      end
      MEM_DROP: begin
        busy = ~dmem.dmem_rvalid;
        if (dmem.dmem_rvalid) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // state, response buffer and EX/MEM register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_mem_q         <= '0;
      ex_mem_q.pc      <= RESET_PC;
      ex_mem_q.trap_pc <= RESET_PC;
      state_q          <= MEM_IDLE;
      rbuf_q           <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      state_q  <= state_d;
      rbuf_q   <= rbuf_d;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & is_store;
  assign dmem.dmem_addr  = {ex_mem_q.alu_csr_result[31:2], 2'b00};
  assign dmem.dmem_wstrb = req ? lsu_wstrb : 4'b0000;
  assign dmem.dmem_wdata = lsu_wdata;

  assign mem_busy_o           = busy;
  assign mem_alu_csr_result_o = ex_mem_q.alu_csr_result;
  assign mem_rd_addr_o        = ex_mem_q.valid ? ex_mem_q.rd_addr : 5'd0;
  assign mem_trap_valid_o     = ex_mem_q.valid & ex_mem_q.trap_valid;

  // MEM/WB payload; a carried EX trap wins over a local misalignment
  always_comb begin
    mem_pipeline_d_o            = '0;
    mem_pipeline_d_o.valid      = ex_mem_q.valid & ~busy;
    mem_pipeline_d_o.stall      = mem_wb_stall_i;
    mem_pipeline_d_o.flush      = mem_wb_flush_i;
    mem_pipeline_d_o.pc         = ex_mem_q.pc;
    mem_pipeline_d_o.result     = is_load ? lsu_load_data : ex_mem_q.alu_csr_result;
    mem_pipeline_d_o.rd_addr    = ex_mem_q.rd_addr;
    mem_pipeline_d_o.trap_valid = ex_mem_q.valid & (ex_mem_q.trap_valid | mis_trap);
    if (ex_mem_q.trap_valid) begin
      mem_pipeline_d_o.trap_mcause = ex_mem_q.trap_mcause;
      mem_pipeline_d_o.trap_pc     = ex_mem_q.trap_pc;
    end else begin
      mem_pipeline_d_o.trap_mcause = is_store ? TRAP_CODE_STORE_ADDR_MISALIGNED
                                              : TRAP_CODE_LOAD_ADDR_MISALIGNED;
      mem_pipeline_d_o.trap_pc     = ex_mem_q.pc;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a small memory model answers the bus, the hazard
// unit is modelled as stall = busy | hold_stall, and every retiring
// instruction is checked against a scoreboard queue of expected results.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        trap;
    logic [5:0]  mcause;
    logic [31:0] tpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_t     ex_d;
  logic        hold_stall, ex_flush, wb_stall, wb_flush, ex_stall;
  logic        busy, trap_o;
  logic [31:0] fwd;
  logic [4:0]  rd_o;
  mem_wb_t     wb;

  mem_stage_if bus();

  mem_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .ex_pipeline_d_i      (ex_d),
    .ex_mem_stall_i       (ex_stall),
    .ex_mem_flush_i       (ex_flush),
    .mem_wb_stall_i       (wb_stall),
    .mem_wb_flush_i       (wb_flush),
    .dmem                 (bus),
    .mem_busy_o           (busy),
    .mem_alu_csr_result_o (fwd),
    .mem_rd_addr_o        (rd_o),
    .mem_trap_valid_o     (trap_o),
    .mem_pipeline_d_o     (wb)
  );

  assign ex_stall = busy | hold_stall;

  // memory model: grant after gnt_delay waiting cycles, rvalid rv_extra cycles after the one following grant
  int          gnt_delay = 0;
  int          rv_extra  = 0;
  int          gnt_cnt;
  int          rv_cnt;
  logic        resp_pend;
  logic [31:0] bus_rdata;

  assign bus.dmem_gnt    = bus.dmem_req && (gnt_cnt >= gnt_delay);
  assign bus.dmem_rvalid = resp_pend && (rv_cnt == 0);
  assign bus.dmem_rdata  = bus_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt   <= 0;
      rv_cnt    <= 0;
      resp_pend <= 1'b0;
    end else begin
      if (bus.dmem_rvalid) resp_pend <= 1'b0;
      else if (resp_pend && rv_cnt > 0) rv_cnt <= rv_cnt - 1;
      if (bus.dmem_req && bus.dmem_gnt) begin
        resp_pend <= 1'b1;
        rv_cnt    <= rv_extra;
        gnt_cnt   <= 0;
      end else if (bus.dmem_req) begin
        gnt_cnt <= gnt_cnt + 1;
      end else begin
        gnt_cnt <= 0;
      end
    end
  end

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // retirement monitor: an instruction leaves MEM when its output is valid and EX/MEM advances
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && wb.valid === 1'b1 && ex_stall === 1'b0) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL retire_unexpected: got result=%h rd=%0d, expected no retirement", wb.result, wb.rd_addr);
      end else begin
        mon_e = sb_q.pop_front();
        if (wb.trap_valid !== mon_e.trap || wb.rd_addr !== mon_e.rd ||
            (!mon_e.trap && wb.result !== mon_e.result) ||
            (mon_e.trap && (wb.trap_mcause !== mon_e.mcause || wb.trap_pc !== mon_e.tpc))) begin
          failures++;
          $display("FAIL %s: got result=%h rd=%0d trap=%b mcause=%0d tpc=%h, expected result=%h rd=%0d trap=%b mcause=%0d tpc=%h",
                   mon_e.name, wb.result, wb.rd_addr, wb.trap_valid, wb.trap_mcause, wb.trap_pc,
                   mon_e.result, mon_e.rd, mon_e.trap, mon_e.mcause, mon_e.tpc);
        end
      end
    end
  end

  function automatic ex_mem_t mk(mem_op_t op, logic [31:0] a, logic [31:0] sd, logic [4:0] rd, logic [31:0] pc);
    ex_mem_t m;
    m                = '0;
    m.valid          = 1'b1;
    m.pc             = pc;
    m.alu_csr_result = a;
    m.store_data     = sd;
    m.mem_op         = op;
    m.rd_addr        = rd;
    return m;
  endfunction

  function automatic exp_t e_ok(string n, logic [31:0] r, logic [4:0] rd);
    exp_t e;
    e.name = n; e.result = r; e.rd = rd; e.trap = 1'b0; e.mcause = '0; e.tpc = '0;
    return e;
  endfunction

  function automatic exp_t e_trap(string n, logic [4:0] rd, logic [5:0] mc, logic [31:0] tpc);
    exp_t e;
    e.name = n; e.result = '0; e.rd = rd; e.trap = 1'b1; e.mcause = mc; e.tpc = tpc;
    return e;
  endfunction

  // present one instruction until EX/MEM accepts it; optionally push its expectation
  task automatic issue(input ex_mem_t ins, input bit push, input exp_t e);
    int n;
    @(negedge clk);
    ex_d = ins;
    if (push) sb_q.push_back(e);
    n = 0;
    #1;
    while (ex_stall && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout %s: got stall held 50 cycles, expected acceptance", e.name);
    end
    @(posedge clk);
    #1;
    ex_d = '0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_%s: got %0d pending busy=%b, expected 0 pending busy=0", nm, sb_q.size(), busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ex_d = mk(MEM_LW, 32'h40, 32'h0, 5'd3, 32'h8);
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.dmem_wstrb !== 4'b0000) begin
      failures++;
      $display("FAIL reset_bus: got req=%b we=%b wstrb=%b, expected 0 0 0000", bus.dmem_req, bus.dmem_we, bus.dmem_wstrb);
    end
    checks++;
    if (busy !== 1'b0 || trap_o !== 1'b0 || rd_o !== 5'd0 || wb.valid !== 1'b0 || wb.trap_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got busy=%b trap=%b rd=%0d valid=%b wbtrap=%b, expected all 0", busy, trap_o, rd_o, wb.valid, wb.trap_valid);
    end
    checks++;
    if (wb.pc !== RST_PC) begin
      failures++;
      $display("FAIL reset_pc: got %h, expected %h", wb.pc, RST_PC);
    end
    ex_d = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lw_basic;
    bus_rdata = 32'hDEAD_BEEF;
    issue(mk(MEM_LW, 32'h100, 32'h0, 5'd5, 32'h40), 1'b1, e_ok("lw_basic", 32'hDEAD_BEEF, 5'd5));
    @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'h100 || bus.dmem_we !== 1'b0 || wb.valid !== 1'b0) begin
      failures++;
      $display("FAIL lw_cycle0: got busy=%b req=%b addr=%h we=%b valid=%b, expected 1 1 00000100 0 0",
               busy, bus.dmem_req, bus.dmem_addr, bus.dmem_we, wb.valid);
    end
    @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || wb.valid !== 1'b1 || wb.result !== 32'hDEAD_BEEF || rd_o !== 5'd5 || fwd !== 32'h100) begin
      failures++;
      $display("FAIL lw_cycle1: got busy=%b valid=%b result=%h rd=%0d fwd=%h, expected 0 1 deadbeef 5 00000100",
               busy, wb.valid, wb.result, rd_o, fwd);
    end
    drain("lw_basic");
  endtask

  task automatic test_load_extension;
    bus_rdata = 32'h8012_3456;
    issue(mk(MEM_LB,  32'h203, 32'h0, 5'd1, 32'h50), 1'b1, e_ok("lb_203",  32'hFFFF_FF80, 5'd1));
    issue(mk(MEM_LBU, 32'h203, 32'h0, 5'd2, 32'h54), 1'b1, e_ok("lbu_203", 32'h0000_0080, 5'd2));
    issue(mk(MEM_LH,  32'h202, 32'h0, 5'd3, 32'h58), 1'b1, e_ok("lh_202",  32'hFFFF_8012, 5'd3));
    issue(mk(MEM_LHU, 32'h202, 32'h0, 5'd4, 32'h5C), 1'b1, e_ok("lhu_202", 32'h0000_8012, 5'd4));
    issue(mk(MEM_LB,  32'h201, 32'h0, 5'd6, 32'h60), 1'b1, e_ok("lb_201",  32'h0000_0034, 5'd6));
    issue(mk(MEM_LH,  32'h200, 32'h0, 5'd7, 32'h64), 1'b1, e_ok("lh_200",  32'h0000_3456, 5'd7));
    issue(mk(MEM_SW,  32'h300, 32'h1, 5'd0, 32'h68), 1'b1, e_ok("sw_300",  32'h0000_0300, 5'd0));
    drain("load_ext");
  endtask

  task automatic test_misaligned_trap;
    ex_mem_t ins;
    issue(mk(MEM_SH, 32'h1001, 32'h0, 5'd0, 32'h80), 1'b1,
          e_trap("sh_mis", 5'd0, TRAP_CODE_STORE_ADDR_MISALIGNED, 32'h80));
    @(negedge clk);
    #2;
    checks++;
    if (bus.dmem_req !== 1'b0 || busy !== 1'b0 || wb.trap_valid !== 1'b1 || wb.trap_mcause !== 6'd6 || trap_o !== 1'b0) begin
      failures++;
      $display("FAIL sh_mis_bus: got req=%b busy=%b trap=%b mcause=%0d carried=%b, expected 0 0 1 6 0",
               bus.dmem_req, busy, wb.trap_valid, wb.trap_mcause, trap_o);
    end
    issue(mk(MEM_LW, 32'h2, 32'h0, 5'd9, 32'h84), 1'b1,
          e_trap("lw_mis", 5'd9, TRAP_CODE_LOAD_ADDR_MISALIGNED, 32'h84));
    ins             = mk(MEM_LW, 32'h3, 32'h0, 5'd10, 32'h88);
    ins.trap_valid  = 1'b1;
    ins.trap_mcause = 6'd2;
    ins.trap_pc     = 32'h0000_0C00;
    issue(ins, 1'b1, e_trap("carried_trap", 5'd10, 6'd2, 32'h0000_0C00));
    @(negedge clk);
    #2;
    checks++;
    if (trap_o !== 1'b1 || bus.dmem_req !== 1'b0 || wb.trap_mcause !== 6'd2) begin
      failures++;
      $display("FAIL carried_trap_out: got trap_o=%b req=%b mcause=%0d, expected 1 0 2", trap_o, bus.dmem_req, wb.trap_mcause);
    end
    drain("misaligned");
  endtask

  task automatic test_store_gnt_delay;
    gnt_delay = 3;
    issue(mk(MEM_SB, 32'h12, 32'h5A5A_5AAB, 5'd0, 32'h90), 1'b1, e_ok("sb_delay", 32'h12, 5'd0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      checks++;
      if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_wstrb !== 4'b0100 ||
          bus.dmem_wdata !== 32'hABAB_ABAB || bus.dmem_addr !== 32'h10 || busy !== 1'b1) begin
        failures++;
        $display("FAIL sb_hold_c%0d: got req=%b we=%b wstrb=%b wdata=%h addr=%h busy=%b, expected 1 1 0100 abababab 00000010 1",
                 i, bus.dmem_req, bus.dmem_we, bus.dmem_wstrb, bus.dmem_wdata, bus.dmem_addr, busy);
      end
    end
    @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || bus.dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL sb_rvalid: got busy=%b req=%b, expected 0 0", busy, bus.dmem_req);
    end
    gnt_delay = 1;
    issue(mk(MEM_SH, 32'h22, 32'h1234_CDEF, 5'd0, 32'h94), 1'b1, e_ok("sh_22", 32'h22, 5'd0));
    @(negedge clk);
    #2;
    checks++;
    if (bus.dmem_wstrb !== 4'b1100 || bus.dmem_wdata !== 32'hCDEF_CDEF || bus.dmem_addr !== 32'h20) begin
      failures++;
      $display("FAIL sh_lanes: got wstrb=%b wdata=%h addr=%h, expected 1100 cdefcdef 00000020",
               bus.dmem_wstrb, bus.dmem_wdata, bus.dmem_addr);
    end
    drain("store");
    gnt_delay = 0;
  endtask

  task automatic test_stall_done;
    bus_rdata = 32'h0000_55AA;
    issue(mk(MEM_LW, 32'h400, 32'h0, 5'd7, 32'hA0), 1'b1, e_ok("lw_done", 32'h0000_55AA, 5'd7));
    hold_stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (wb.valid !== 1'b1 || wb.result !== 32'h0000_55AA) begin
      failures++;
      $display("FAIL done_rvalid: got valid=%b result=%h, expected 1 000055aa", wb.valid, wb.result);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_rdata = 32'h1111_2222;
      #2;
      checks++;
      if (dut.state_q !== MEM_DONE || wb.result !== 32'h0000_55AA || busy !== 1'b0 || wb.valid !== 1'b1) begin
        failures++;
        $display("FAIL done_hold_c%0d: got state=%0d result=%h busy=%b valid=%b, expected 3 000055aa 0 1",
                 i, dut.state_q, wb.result, busy, wb.valid);
      end
    end
    @(negedge clk);
    hold_stall = 1'b0;
    @(negedge clk);
    #2;
    checks++;
    if (dut.state_q !== MEM_IDLE) begin
      failures++;
      $display("FAIL done_release: got state=%0d, expected 0", dut.state_q);
    end
    drain("stall_done");
  endtask

  task automatic test_flush_drop;
    exp_t dummy;
    dummy = e_ok("flushed_lw", 32'h0, 5'd0);
    rv_extra  = 2;
    bus_rdata = 32'hBAD0_BAD0;
    issue(mk(MEM_LW, 32'h500, 32'h0, 5'd11, 32'hB0), 1'b0, dummy);
    @(negedge clk);
    @(negedge clk);
    ex_flush = 1'b1;
    #2;
    checks++;
    if (dut.state_q !== MEM_WAIT || busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_wait: got state=%0d busy=%b, expected 2 1", dut.state_q, busy);
    end
    @(negedge clk);
    ex_flush = 1'b0;
    #2;
    checks++;
    if (dut.state_q !== MEM_DROP || busy !== 1'b1 || wb.valid !== 1'b0 || rd_o !== 5'd0) begin
      failures++;
      $display("FAIL drop_state: got state=%0d busy=%b valid=%b rd=%0d, expected 4 1 0 0", dut.state_q, busy, wb.valid, rd_o);
    end
    @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || wb.valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_rvalid: got busy=%b valid=%b, expected 0 0", busy, wb.valid);
    end
    @(negedge clk);
    #2;
    checks++;
    if (dut.state_q !== MEM_IDLE) begin
      failures++;
      $display("FAIL drop_exit: got state=%0d, expected 0", dut.state_q);
    end
    rv_extra  = 0;
    bus_rdata = 32'h1234_5678;
    issue(mk(MEM_LW, 32'h504, 32'h0, 5'd12, 32'hB4), 1'b1, e_ok("lw_after_drop", 32'h1234_5678, 5'd12));
    drain("flush_drop");
  endtask

  task automatic test_reset_in_req;
    exp_t dummy;
    dummy = e_ok("reset_lw", 32'h0, 5'd0);
    gnt_delay = 5;
    issue(mk(MEM_LW, 32'h600, 32'h0, 5'd13, 32'hC0), 1'b0, dummy);
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (dut.state_q !== MEM_REQ || bus.dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL req_before_rst: got state=%0d req=%b, expected 1 1", dut.state_q, bus.dmem_req);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || wb.valid !== 1'b0 || busy !== 1'b0 || rd_o !== 5'd0) begin
      failures++;
      $display("FAIL rst_in_req: got req=%b valid=%b busy=%b rd=%0d, expected 0 0 0 0", bus.dmem_req, wb.valid, busy, rd_o);
    end
    @(negedge clk);
    rst       = 1'b0;
    gnt_delay = 0;
    bus_rdata = 32'hCAFE_F00D;
    issue(mk(MEM_LW, 32'h604, 32'h0, 5'd14, 32'hC4), 1'b1, e_ok("lw_after_rst", 32'hCAFE_F00D, 5'd14));
    drain("reset_in_req");
  endtask

  initial begin
    ex_d       = '0;
    hold_stall = 1'b0;
    ex_flush   = 1'b0;
    wb_stall   = 1'b0;
    wb_flush   = 1'b0;
    bus_rdata  = '0;
    test_reset;
    test_lw_basic;
    test_load_extension;
    test_misaligned_trap;
    test_store_gnt_delay;
    test_stall_done;
    test_flush_drop;
    test_reset_in_req;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier finish");
    $fatal(1);
  end

endmodule
